// File: rtl/hub75_panel_capture.sv
// HUB75 panel emulator: shifts/latches column data and integrates OE-on time per pixel into RAM for loopback self-test.
// Define HUB75_CAPTURE_SAT_EN to make the accumulators saturate at 2**ACC_BITS-1 instead of wrapping.
module hub75_panel_capture #(
    parameter int PANEL_WIDTH = 64,
    parameter int ADDR_BITS   = 4,
    parameter int ACC_BITS    = 4
) (
    input  logic                           pixel_clk,
    input  logic                           n_reset,
    input  logic [1:0]                     hub75_red,
    input  logic [1:0]                     hub75_green,
    input  logic [1:0]                     hub75_blue,
    input  logic [ADDR_BITS-1:0]           hub75_addr,
    input  logic                           hub75_clk,
    input  logic                           hub75_latch,
    input  logic                           hub75_oe,
    input  logic                           clear,
    output logic                           busy,
    output logic                           overrun,
    input  logic                           rd_en,
    input  logic [$clog2(PANEL_WIDTH)-1:0] rd_x,
    input  logic [ADDR_BITS:0]             rd_y,
    output logic                           rd_valid,
    output logic [ACC_BITS-1:0]            rd_red,
    output logic [ACC_BITS-1:0]            rd_green,
    output logic [ACC_BITS-1:0]            rd_blue,
    output logic [15:0]                    oe_total
);
    localparam int XW    = $clog2(PANEL_WIDTH);
    localparam int DEPTH = (2**ADDR_BITS) * PANEL_WIDTH;
    localparam int AW    = ADDR_BITS + XW;
    localparam int WW    = 3 * ACC_BITS;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COMMIT = 2'd1, ST_CLEAR = 2'd2} state_t;

    function automatic logic [ACC_BITS-1:0] acc_add(input logic [ACC_BITS-1:0] acc,
                                                    input logic [15:0] run, input logic en);
        logic [16:0] sum;
        sum = en ? (17'(acc) + 17'(run)) : 17'(acc);
`ifdef HUB75_CAPTURE_SAT_EN
        if (sum > 17'({ACC_BITS{1'b1}})) acc_add = {ACC_BITS{1'b1}};
        else acc_add = sum[ACC_BITS-1:0];
`else
        acc_add = sum[ACC_BITS-1:0];
`endif
    endfunction

    // rgb is {red, green, blue} enables for one pixel
    function automatic logic [WW-1:0] pix_add(input logic [WW-1:0] q, input logic [15:0] run,
                                              input logic [2:0] rgb);
        pix_add = {acc_add(q[3*ACC_BITS-1:2*ACC_BITS], run, rgb[2]),
                   acc_add(q[2*ACC_BITS-1:ACC_BITS], run, rgb[1]),
                   acc_add(q[ACC_BITS-1:0], run, rgb[0])};
    endfunction

    state_t                    state_r, state_next_s;
    logic [AW-1:0]             cnt_r, cnt_next_s;
    logic                      busy_r, overrun_r, rd_valid_r, rd_bank_r;
    logic                      clk_prev_r, latch_prev_r;
    logic [XW-1:0]             col_r, wcol_s;
    logic [PANEL_WIDTH-1:0][5:0] shift_line_r, shift_next_s, latch_line_r, snap_line_r;
    logic [15:0]               oe_run_r, oe_total_r, snap_run_r;
    logic [ADDR_BITS-1:0]      run_addr_r, snap_addr_r;
    logic [5:0]                rgb_s;
    logic                      shift_rise_s, latch_rise_s, oe_on_s, commit_req_s, commit_go_s, rd_acc_s;
    logic                      we_s;
    logic [AW-1:0]             waddr_s, raddr_s;
    logic [WW-1:0]             wdata_up_s, wdata_lo_s, q_up_r, q_lo_r, rd_sel_s;
    logic [WW-1:0]             mem_up_r [DEPTH];
    logic [WW-1:0]             mem_lo_r [DEPTH];

    assign rgb_s        = {hub75_blue, hub75_green, hub75_red};
    assign shift_rise_s = hub75_clk & ~clk_prev_r;
    assign latch_rise_s = hub75_latch & ~latch_prev_r;
    assign oe_on_s      = ~hub75_oe;
    assign commit_req_s = (oe_run_r != 16'd0) && (latch_rise_s || (hub75_addr != run_addr_r));
    assign commit_go_s  = commit_req_s && (state_r == ST_IDLE) && !clear;
    assign rd_acc_s     = rd_en && (state_r == ST_IDLE);

    // Shift line with the current shift applied, so a coincident latch copies the new bit
    always_comb begin
        shift_next_s = shift_line_r;
        if (shift_rise_s) shift_next_s[col_r] = rgb_s;
        else shift_next_s = shift_line_r;
    end

    // Edge detection, column shifting and line latching
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            clk_prev_r   <= 1'b0;
            latch_prev_r <= 1'b0;
            col_r        <= '0;
            shift_line_r <= '0;
            latch_line_r <= '0;
        end else begin
            clk_prev_r   <= hub75_clk;
            latch_prev_r <= hub75_latch;
            shift_line_r <= shift_next_s;
            if (latch_rise_s) begin
                latch_line_r <= shift_next_s;
                col_r        <= '0;
            end else if (shift_rise_s) begin
                col_r <= col_r + XW'(1);
            end
        end
    end

    // OE run integration and commit snapshot
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            oe_run_r    <= 16'd0;
            oe_total_r  <= 16'd0;
            run_addr_r  <= '0;
            snap_run_r  <= 16'd0;
            snap_addr_r <= '0;
            snap_line_r <= '0;
        end else begin
            oe_total_r <= oe_total_r + {15'd0, oe_on_s};
            if (commit_req_s) oe_run_r <= {15'd0, oe_on_s};
            else if (oe_on_s && (oe_run_r != 16'hFFFF)) oe_run_r <= oe_run_r + 16'd1;
            if (oe_on_s && ((oe_run_r == 16'd0) || commit_req_s)) run_addr_r <= hub75_addr;
            if (commit_go_s) begin
                snap_line_r <= latch_line_r;
                snap_run_r  <= oe_run_r;
                snap_addr_r <= run_addr_r;
            end
        end
    end

    // Next-state logic for CLEAR / IDLE / COMMIT sequencing
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + AW'(1);
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = '0;
                if (clear) state_next_s = ST_CLEAR;
                else if (commit_req_s) state_next_s = ST_COMMIT;
                else state_next_s = ST_IDLE;
            end
            ST_COMMIT: begin
                if (cnt_r == AW'(PANEL_WIDTH)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_COMMIT;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: begin
                state_next_s = ST_CLEAR;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FSM state, status flags and readback handshake
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= ST_CLEAR;
            cnt_r      <= '0;
            busy_r     <= 1'b1;
            overrun_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_bank_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) rd_bank_r <= rd_y[ADDR_BITS];
            if (commit_req_s && (state_r != ST_IDLE)) overrun_r <= 1'b1;
            else if ((state_next_s == ST_CLEAR) && (state_r != ST_CLEAR)) overrun_r <= 1'b0;
        end
    end

    // RAM port control: column c is read while column c-1 is written back
    always_comb begin
        wcol_s     = cnt_r[XW-1:0] - XW'(1);
        raddr_s    = (state_r == ST_COMMIT) ? {snap_addr_r, cnt_r[XW-1:0]} : {rd_y[ADDR_BITS-1:0], rd_x};
        we_s       = 1'b0;
        waddr_s    = cnt_r;
        wdata_up_s = '0;
        wdata_lo_s = '0;
        case (state_r)
            ST_CLEAR: we_s = 1'b1;
            ST_COMMIT: begin
                if (cnt_r != '0) begin
                    we_s       = 1'b1;
                    waddr_s    = {snap_addr_r, wcol_s};
                    wdata_up_s = pix_add(q_up_r, snap_run_r,
                                         {snap_line_r[wcol_s][0], snap_line_r[wcol_s][2], snap_line_r[wcol_s][4]});
                    wdata_lo_s = pix_add(q_lo_r, snap_run_r,
                                         {snap_line_r[wcol_s][1], snap_line_r[wcol_s][3], snap_line_r[wcol_s][5]});
                end else begin
                    we_s = 1'b0;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    // Accumulator banks (upper/lower half), one-cycle registered read
    always_ff @(posedge pixel_clk) begin
        if (we_s) begin
            mem_up_r[waddr_s] <= wdata_up_s;
            mem_lo_r[waddr_s] <= wdata_lo_s;
        end
        q_up_r <= mem_up_r[raddr_s];
        q_lo_r <= mem_lo_r[raddr_s];
    end

    // Readback data is forced to zero whenever it is not valid
    always_comb begin
        rd_sel_s = rd_bank_r ? q_lo_r : q_up_r;
        if (rd_valid_r) begin
            rd_red   = rd_sel_s[3*ACC_BITS-1:2*ACC_BITS];
            rd_green = rd_sel_s[2*ACC_BITS-1:ACC_BITS];
            rd_blue  = rd_sel_s[ACC_BITS-1:0];
        end else begin
            rd_red   = '0;
            rd_green = '0;
            rd_blue  = '0;
        end
    end

    assign busy     = busy_r;
    assign overrun  = overrun_r;
    assign rd_valid = rd_valid_r;
    assign oe_total = oe_total_r;
endmodule

// File: tb/tb_hub75_panel_capture.sv
// Directed self-checking bench for hub75_panel_capture (honours HUB75_CAPTURE_SAT_EN for the saturation case).
module tb_hub75_panel_capture;
    logic       pixel_clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [1:0] hub75_red = 2'b00, hub75_green = 2'b00, hub75_blue = 2'b00;
    logic [3:0] hub75_addr = 4'd0;
    logic       hub75_clk = 1'b0, hub75_latch = 1'b0, hub75_oe = 1'b1, clear = 1'b0;
    logic       busy, overrun, rd_en = 1'b0, rd_valid;
    logic [5:0] rd_x = 6'd0;
    logic [4:0] rd_y = 5'd0;
    logic [3:0] rd_red, rd_green, rd_blue;
    logic [15:0] oe_total;

    int n_cmp = 0;
    int n_bad = 0;

    hub75_panel_capture #(.PANEL_WIDTH(64), .ADDR_BITS(4), .ACC_BITS(4)) dut (
        .pixel_clk(pixel_clk), .n_reset(n_reset),
        .hub75_red(hub75_red), .hub75_green(hub75_green), .hub75_blue(hub75_blue),
        .hub75_addr(hub75_addr), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_oe(hub75_oe),
        .clear(clear), .busy(busy), .overrun(overrun),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue), .oe_total(oe_total)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 5000) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic shift_px(input logic [5:0] rgb);
        {hub75_blue, hub75_green, hub75_red} = rgb;
        hub75_clk = 1'b1;
        tick(1);
        hub75_clk = 1'b0;
        tick(1);
    endtask

    task automatic pulse_latch();
        hub75_latch = 1'b1;
        tick(1);
        hub75_latch = 1'b0;
        tick(1);
    endtask

    task automatic run_oe(input logic [3:0] a, input int n);
        hub75_addr = a;
        hub75_oe   = 1'b0;
        tick(n);
        hub75_oe   = 1'b1;
    endtask

    task automatic read_red(input string tag, input logic [5:0] x, input logic [4:0] y, input logic [3:0] exp_r);
        rd_x  = x;
        rd_y  = y;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_red"}, {28'd0, rd_red}, {28'd0, exp_r});
        check({tag, "_gb"}, {24'd0, rd_green, rd_blue}, 32'd0);
        tick(1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    function automatic logic [5:0] pat(input int i);
        pat = 6'(i + (i / 64) * 32);
    endfunction

    int cyc;
    logic [3:0] exp_sat, exp_acc2;
    logic [5:0] exp_col;

    initial begin
`ifdef HUB75_CAPTURE_SAT_EN
        exp_sat  = 4'd15;
        exp_acc2 = 4'd15;
`else
        exp_sat  = 4'd4;
        exp_acc2 = 4'd6;
`endif
        // 1: reset and initial clear
        tick(3);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_oe_total", {16'd0, oe_total}, 32'd0);
        n_reset = 1'b1;
        wait_idle(cyc);
        check("init_clear_cycles", cyc, 32'd1024);
        read_red("t1_p00", 6'd0, 5'd0, 4'd0);
        read_red("t1_p53", 6'd5, 5'd3, 4'd0);
        read_red("t1_p6331", 6'd63, 5'd31, 4'd0);

        // 2: single commit, red upper pixel at column 5
        for (int i = 0; i < 64; i++) shift_px((i == 5) ? 6'b000001 : 6'b000000);
        pulse_latch();
        run_oe(4'd3, 3);
        tick(1);
        hub75_addr = 4'd4;
        tick(1);
        check("t2_busy_start", {31'd0, busy}, 32'd1);
        wait_idle(cyc);
        check("t2_commit_cycles", cyc, 32'd65);
        read_red("t2_p53", 6'd5, 5'd3, 4'd3);
        read_red("t2_p519", 6'd5, 5'd19, 4'd0);
        read_red("t2_p63", 6'd6, 5'd3, 4'd0);
        check("t2_oe_total", {16'd0, oe_total}, 32'd3);

        // 3: clear, then an over-range run
        pulse_clear();
        wait_idle(cyc);
        check("t3_clear_cycles", cyc, 32'd1024);
        run_oe(4'd3, 20);
        tick(1);
        hub75_addr = 4'd4;
        tick(1);
        wait_idle(cyc);
        read_red("t3_p53", 6'd5, 5'd3, exp_sat);
        check("t3_oe_total", {16'd0, oe_total}, 32'd23);

        // 4: second commit request while busy
        hub75_addr = 4'd3;
        hub75_oe   = 1'b0;
        tick(2);
        hub75_addr = 4'd4;
        tick(10);
        hub75_addr = 4'd5;
        hub75_oe   = 1'b1;
        tick(1);
        rd_x  = 6'd5;
        rd_y  = 5'd3;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t4_rd_while_busy", {31'd0, rd_valid}, 32'd0);
        wait_idle(cyc);
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        read_red("t4_p53", 6'd5, 5'd3, exp_acc2);
        read_red("t4_p54", 6'd5, 5'd4, 4'd0);
        check("t4_oe_total", {16'd0, oe_total}, 32'd35);
        pulse_clear();
        check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
        wait_idle(cyc);
        read_red("t4_clr_p53", 6'd5, 5'd3, 4'd0);
        read_red("t4_clr_p00", 6'd0, 5'd0, 4'd0);

        // 5: pointer wrap and re-latch
        for (int i = 0; i < 70; i++) shift_px(pat(i));
        pulse_latch();
        for (int j = 0; j < 8; j++) begin
            exp_col = (j < 6) ? pat(64 + j) : pat(j);
            check("t5_wrap_col", {26'd0, dut.latch_line_r[j]}, {26'd0, exp_col});
        end
        for (int k = 0; k < 3; k++) shift_px(6'(50 + k));
        pulse_latch();
        for (int j = 0; j < 3; j++) check("t5_rewrite_col", {26'd0, dut.latch_line_r[j]}, 32'(50 + j));
        check("t5_col3_kept", {26'd0, dut.latch_line_r[3]}, {26'd0, pat(67)});
        {hub75_blue, hub75_green, hub75_red} = 6'h2A;
        hub75_clk   = 1'b1;
        hub75_latch = 1'b1;
        tick(1);
        hub75_clk   = 1'b0;
        hub75_latch = 1'b0;
        tick(1);
        check("t5_same_cycle", {26'd0, dut.latch_line_r[0]}, 32'h2A);

        // 6: reset in the middle of a commit
        {hub75_blue, hub75_green, hub75_red} = 6'd0;
        run_oe(4'd3, 3);
        tick(1);
        hub75_addr = 4'd4;
        tick(30);
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        n_reset = 1'b0;
        tick(1);
        check("t6_rst_busy", {31'd0, busy}, 32'd1);
        check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        check("t6_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("t6_rst_red", {28'd0, rd_red}, 32'd0);
        check("t6_rst_oe_total", {16'd0, oe_total}, 32'd0);
        n_reset = 1'b1;
        wait_idle(cyc);
        check("t6_clear_cycles", cyc, 32'd1024);
        read_red("t6_p03", 6'd0, 5'd3, 4'd0);
        read_red("t6_p53", 6'd5, 5'd3, 4'd0);
        check("t6_oe_total", {16'd0, oe_total}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
